// File: rtl/stacked_array_feeder_if.sv
// Bundle of the upstream vector handshake and the array-side drive signals.
// The feeder takes the slave side; whoever pushes vectors and watches the
// array drive takes the master side.
`timescale 1ns/1ps
interface stacked_array_feeder_if #(
  parameter int WIDTH               = 8,
  parameter int ARRAY_COUNT         = 3,
  parameter int CELL_MEM_ADDR_WIDTH = 4
);
  logic                           s_valid;
  logic                           s_ready;
  logic [WIDTH*ARRAY_COUNT-1:0]   s_data;
  logic [31:0]                    ctrl_in;
  logic                           ce;
  logic [31:0]                    ctrl;
  logic [CELL_MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH*ARRAY_COUNT-1:0]   x_ins;
  logic                           busy;

  modport master (
    output s_valid, s_data, ctrl_in,
    input  s_ready, ce, ctrl, mem_addr, x_ins, busy
  );

  modport slave (
    input  s_valid, s_data, ctrl_in,
    output s_ready, ce, ctrl, mem_addr, x_ins, busy
  );
endinterface

// File: rtl/stacked_array_feeder.sv
// Upstream feeder for the stacked systolic array. Buffers incoming packed
// vectors in a small FIFO, replays each one on x_ins while sweeping every
// weight address with ce high, and after the last vector of a burst clocks
// the array pipeline with zero vectors so results drain out. Every array-side
// output comes straight from a register.
`timescale 1ns/1ps
module stacked_array_feeder #(
  parameter int WIDTH                 = 8,
  parameter int ARRAY_COUNT           = 3,
  parameter int CELLS_PER_ARRAY_COUNT = 3,
  parameter int CELL_MEM_ADDR_WIDTH   = 4,
  parameter int ADDR_COUNT            = 16,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stacked_array_feeder_if.slave bus
);

  localparam int DATA_W  = WIDTH * ARRAY_COUNT;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = (CELLS_PER_ARRAY_COUNT > 1) ? $clog2(CELLS_PER_ARRAY_COUNT) : 1;
  localparam int AW      = CELL_MEM_ADDR_WIDTH;

  localparam logic [AW-1:0]      LAST_ADDR  = AW'(ADDR_COUNT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(CELLS_PER_ARRAY_COUNT - 1);
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Ready depends only on the registered occupancy, never on the pop, so
  // a slot freed this cycle is offered to upstream one cycle later.
  assign bus.s_ready = (count != FULL_COUNT);
  assign push        = bus.s_valid && bus.s_ready;
  assign fifo_empty  = (count == '0);
  assign fifo_head   = fifo_mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.s_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  state_t             state_reg;
  state_t             state_next;
  logic               ce_reg;
  logic               ce_next;
  logic               busy_reg;
  logic               busy_next;
  logic [31:0]        ctrl_reg;
  logic [31:0]        ctrl_next;
  logic [AW-1:0]      mem_addr_reg;
  logic [AW-1:0]      mem_addr_next;
  logic [DATA_W-1:0]  x_ins_reg;
  logic [DATA_W-1:0]  x_ins_next;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_next;

  // State and scalar output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ce_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      ctrl_reg      <= '0;
      mem_addr_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ce_reg        <= ce_next;
      busy_reg      <= busy_next;
      ctrl_reg      <= ctrl_next;
      mem_addr_reg  <= mem_addr_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Vector register, one lane per stacked array; lanes pass through bit-exact.
  for (genvar gi = 0; gi < ARRAY_COUNT; gi++) begin : g_lane
    // Lane gi of the vector presented to array gi.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_ins_reg[gi*WIDTH +: WIDTH] <= '0;
      end else begin
        x_ins_reg[gi*WIDTH +: WIDTH] <= x_ins_next[gi*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output decode for IDLE / FEED / DRAIN.
  always_comb begin
    state_next     = state_reg;
    ce_next        = ce_reg;
    busy_next      = busy_reg;
    ctrl_next      = ctrl_reg;
    mem_addr_next  = mem_addr_reg;
    x_ins_next     = x_ins_reg;
    drain_cnt_next = drain_cnt_reg;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        ce_next       = 1'b0;
        busy_next     = 1'b0;
        x_ins_next    = '0;
        mem_addr_next = '0;
        if (!fifo_empty) begin
          // Start of a burst: the control word is sampled only here.
          pop        = 1'b1;
          x_ins_next = fifo_head;
          ctrl_next  = bus.ctrl_in;
          ce_next    = 1'b1;
          busy_next  = 1'b1;
          state_next = FEED;
        end
      end

      FEED: begin
        ce_next   = 1'b1;
        busy_next = 1'b1;
        if (mem_addr_reg == LAST_ADDR) begin
          mem_addr_next = '0;
          if (!fifo_empty) begin
            // Chain straight into the next vector without a bubble.
            pop        = 1'b1;
            x_ins_next = fifo_head;
          end else begin
            x_ins_next     = '0;
            drain_cnt_next = DRAIN_LOAD;
            state_next     = DRAIN;
          end
        end else begin
          mem_addr_next = mem_addr_reg + AW'(1);
        end
      end

      DRAIN: begin
        // New arrivals wait in the FIFO until the drain has finished.
        x_ins_next    = '0;
        mem_addr_next = '0;
        if (drain_cnt_reg == '0) begin
          ce_next    = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          ce_next        = 1'b1;
          busy_next      = 1'b1;
          drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        ce_next       = 1'b0;
        busy_next     = 1'b0;
        x_ins_next    = '0;
        mem_addr_next = '0;
      end
    endcase
  end

  assign bus.ce       = ce_reg;
  assign bus.busy     = busy_reg;
  assign bus.ctrl     = ctrl_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.x_ins    = x_ins_reg;

endmodule

// File: tb/tb_stacked_array_feeder.sv
// Bench for stacked_array_feeder. The reference model thinks in terms of a
// stream of output slots: every vector expands into ADDR_COUNT feed slots,
// the end of a burst into CELLS_PER_ARRAY_COUNT drain slots, and after a
// drain exactly one idle slot follows before anything new starts.
`timescale 1ns/1ps
module tb_stacked_array_feeder;

  localparam int WIDTH       = 8;
  localparam int ARRAY_COUNT = 3;
  localparam int CELLS       = 3;
  localparam int AW          = 4;
  localparam int ADDR_COUNT  = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int DW          = WIDTH * ARRAY_COUNT;
  localparam int OBS_W       = 1 + AW + DW + 32 + 1 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stacked_array_feeder_if #(
    .WIDTH(WIDTH), .ARRAY_COUNT(ARRAY_COUNT), .CELL_MEM_ADDR_WIDTH(AW)
  ) bus ();

  stacked_array_feeder #(
    .WIDTH(WIDTH), .ARRAY_COUNT(ARRAY_COUNT), .CELLS_PER_ARRAY_COUNT(CELLS),
    .CELL_MEM_ADDR_WIDTH(AW), .ADDR_COUNT(ADDR_COUNT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          feed;
    logic          ce;
    logic [AW-1:0] addr;
    logic [DW-1:0] x;
  } slot_t;

  slot_t         slots[$];
  logic [DW-1:0] fifo_q[$];
  int            kind;      // 0 idle, 1 feeding, 2 draining
  logic          m_ce;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_x;
  logic [31:0]   m_ctrl;

  wire [OBS_W-1:0] dut_obs = {bus.ce, bus.mem_addr, bus.x_ins, bus.ctrl, bus.busy, bus.s_ready};

  function automatic logic [OBS_W-1:0] exp_obs();
    return {m_ce, m_addr, m_x, m_ctrl, (kind != 0), (fifo_q.size() < FIFO_DEPTH)};
  endfunction

  function automatic void model_reset();
    fifo_q.delete();
    slots.delete();
    kind   = 0;
    m_ce   = 1'b0;
    m_addr = '0;
    m_x    = '0;
    m_ctrl = '0;
  endfunction

  function automatic void load_vector(input logic [DW-1:0] v);
    for (int a = 0; a < ADDR_COUNT; a++) begin
      slots.push_back('{feed: 1'b1, ce: 1'b1, addr: AW'(a), x: v});
    end
  endfunction

  // Advance the model by one clock edge with the inputs seen at that edge.
  function automatic bit model_edge(input bit v, input logic [DW-1:0] d, input logic [31:0] c);
    bit    accepted;
    slot_t s;
    accepted = v && (fifo_q.size() < FIFO_DEPTH);
    if (slots.size() == 0) begin
      if (kind == 1) begin
        if (fifo_q.size() > 0) begin
          load_vector(fifo_q.pop_front());
        end else begin
          for (int k = 0; k < CELLS; k++) begin
            slots.push_back('{feed: 1'b0, ce: 1'b1, addr: '0, x: '0});
          end
        end
      end else if (kind == 0 && fifo_q.size() > 0) begin
        load_vector(fifo_q.pop_front());
        m_ctrl = c;
      end
    end
    if (slots.size() > 0) begin
      s      = slots.pop_front();
      m_ce   = s.ce;
      m_addr = s.addr;
      m_x    = s.x;
      kind   = s.feed ? 1 : 2;
    end else begin
      m_ce   = 1'b0;
      m_addr = '0;
      m_x    = '0;
      kind   = 0;
    end
    if (accepted) fifo_q.push_back(d);
    return accepted;
  endfunction

  // Drive one cycle of inputs (called at a falling edge), clock, return at next falling edge.
  task automatic run_cycle(input bit v, input logic [DW-1:0] d, input logic [31:0] c, output bit acc);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.ctrl_in = c;
    @(posedge clk);
    acc = model_edge(v, d, c);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit acc;
    @(negedge clk);
    n_cmp++;
    if ({bus.ce, bus.mem_addr, bus.x_ins, bus.ctrl, bus.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.ce, bus.mem_addr, bus.x_ins, bus.ctrl, bus.busy});
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, '0, 32'h55, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
    end
  endtask

  task automatic test_single();
    bit acc;
    int feed_ce = 0;
    int drain_ce = 0;
    for (int i = 0; i < 25; i++) begin
      run_cycle(i == 0, (i == 0) ? 24'h030201 : 24'h0, 32'h0, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
      if (bus.ce && bus.x_ins == 24'h030201) feed_ce++;
      if (bus.ce && bus.x_ins == 24'h0) drain_ce++;
    end
    n_cmp++;
    if (feed_ce !== ADDR_COUNT) begin
      n_bad++;
      $display("FAIL single_feed_count got=%0d exp=%0d", feed_ce, ADDR_COUNT);
    end
    n_cmp++;
    if (drain_ce !== CELLS) begin
      n_bad++;
      $display("FAIL single_drain_count got=%0d exp=%0d", drain_ce, CELLS);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int ce_total = 0;
    bit seam = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_x = '0;
    logic prev_ce = 1'b0;
    for (int i = 0; i < 42; i++) begin
      run_cycle(i < 2, (i == 0) ? 24'h0A0B0C : 24'h7F80FF, 32'h3, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
      if (bus.ce) ce_total++;
      if (prev_ce && prev_addr == AW'(ADDR_COUNT - 1) && prev_x == 24'h0A0B0C &&
          bus.ce && bus.mem_addr == '0 && bus.x_ins == 24'h7F80FF) seam = 1'b1;
      prev_ce = bus.ce; prev_addr = bus.mem_addr; prev_x = bus.x_ins;
    end
    n_cmp++;
    if (ce_total !== 2 * ADDR_COUNT + CELLS) begin
      n_bad++;
      $display("FAIL b2b_ce_total got=%0d exp=%0d", ce_total, 2 * ADDR_COUNT + CELLS);
    end
    n_cmp++;
    if (seam !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_seam got=%0d exp=1", seam);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int idx = 0;
    bit saw_stall = 1'b0;
    logic [DW-1:0] sent[6];
    logic [DW-1:0] seen[$];
    for (int k = 0; k < 6; k++) sent[k] = {8'(k + 1), 16'($urandom)};
    for (int i = 0; i < 6 * ADDR_COUNT + 12; i++) begin
      if (idx < 6 && !bus.s_ready) saw_stall = 1'b1;
      run_cycle(idx < 6, (idx < 6) ? sent[idx] : 24'h0, 32'h9, acc);
      if (acc) idx++;
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
      if (bus.ce && bus.mem_addr == '0 && bus.x_ins != '0) seen.push_back(bus.x_ins);
    end
    n_cmp++;
    if (saw_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_stall got=%0d exp=1", saw_stall);
    end
    n_cmp++;
    if (seen.size() !== 6) begin
      n_bad++;
      $display("FAIL backpressure_count got=%0d exp=6", seen.size());
    end
    for (int k = 0; k < 6 && k < seen.size(); k++) begin
      n_cmp++;
      if (seen[k] !== sent[k]) begin
        n_bad++;
        $display("FAIL backpressure_order idx=%0d got=%h exp=%h", k, seen[k], sent[k]);
      end
    end
  endtask

  task automatic test_drain_arrival();
    bit acc;
    for (int i = 0; i < 48; i++) begin
      run_cycle(i == 0 || i == 19, (i == 0) ? 24'h112233 : 24'h445566, 32'h4, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL drain_arrival cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
      if (i == 20) begin
        n_cmp++;
        if ({bus.ce, bus.busy} !== 2'b00) begin
          n_bad++;
          $display("FAIL drain_gap got=%b exp=00", {bus.ce, bus.busy});
        end
      end
      if (i == 21) begin
        n_cmp++;
        if ({bus.ce, bus.mem_addr, bus.x_ins} !== {1'b1, AW'(0), 24'h445566}) begin
          n_bad++;
          $display("FAIL drain_restart got=%h exp=%h", {bus.ce, bus.mem_addr, bus.x_ins}, {1'b1, AW'(0), 24'h445566});
        end
      end
    end
  endtask

  task automatic test_ctrl_latch();
    bit acc;
    int bad_ctrl = 0;
    for (int i = 0; i < 60; i++) begin
      run_cycle(i == 0 || i == 8 || i == 40,
                (i == 0) ? 24'hA1A2A3 : (i == 8) ? 24'hB1B2B3 : 24'hC1C2C3,
                (i < 5) ? 32'h1 : 32'h2, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL ctrl_latch cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
      if (i >= 1 && i < 40 && bus.busy && bus.ctrl !== 32'h1) bad_ctrl++;
    end
    n_cmp++;
    if (bad_ctrl !== 0) begin
      n_bad++;
      $display("FAIL ctrl_held got=%0d wrong cycles exp=0", bad_ctrl);
    end
    n_cmp++;
    if (bus.ctrl !== 32'h2) begin
      n_bad++;
      $display("FAIL ctrl_relatch got=%h exp=%h", bus.ctrl, 32'h2);
    end
  endtask

  task automatic test_random();
    bit acc;
    int density;
    for (int i = 0; i < 700; i++) begin
      density = (i < 640) ? ((i / 160) % 4) : 4;
      run_cycle((density < 4) && ($urandom_range(0, 3) < 3 - density + 1) && ($urandom_range(0, 7) < 7 - 2 * density),
                24'($urandom), $urandom, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
    end
  endtask

  task automatic test_reset_mid_feed();
    bit acc;
    for (int i = 0; i < 6; i++) begin
      run_cycle(i < 3, 24'h100000 + 24'(i), 32'h7, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ce, bus.mem_addr, bus.x_ins, bus.ctrl, bus.busy} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=0", {bus.ce, bus.mem_addr, bus.x_ins, bus.ctrl, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      run_cycle(1'b0, '0, 32'h8, acc);
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, dut_obs, exp_obs());
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.ctrl_in = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drain_arrival();
    test_ctrl_latch();
    test_random();
    test_reset_mid_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stacked_array_feeder.md
Name: stacked_array_feeder

Overview:
- Upstream stage of the stacked systolic array.
- Accepts packed input vectors (one WIDTH lane per array) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each vector on x_ins while sweeping mem_addr through every weight address with ce asserted, then drains the array pipeline with zero vectors.
- Drives the array's clk-domain ce, ctrl, mem_addr and x_ins directly; all outputs registered.

Parameters:
- WIDTH, 8, bits per lane.
- ARRAY_COUNT, 3, number of lanes / stacked arrays.
- CELLS_PER_ARRAY_COUNT, 3, cells per array; sets drain length.
- CELL_MEM_ADDR_WIDTH, 4, width of mem_addr.
- ADDR_COUNT, 16, weight addresses swept per vector; 1 <= ADDR_COUNT <= 2**CELL_MEM_ADDR_WIDTH.
- FIFO_DEPTH, 4, input buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  input vector valid.
- s_ready  out  1  FIFO can accept (= !full).
- s_data  in  WIDTH*ARRAY_COUNT  packed vector, lane i at bits [(i+1)*WIDTH-1 : i*WIDTH].
- ctrl_in  in  32  control word for the array.
- ce  out  1  array clock enable.
- ctrl  out  32  registered control word to the array.
- mem_addr  out  CELL_MEM_ADDR_WIDTH  weight address.
- x_ins  out  WIDTH*ARRAY_COUNT  packed vector to the array.
- busy  out  1  high in FEED or DRAIN.

Behaviour:
- Reset (async, immediate): FSM=IDLE; FIFO emptied; ce=0, mem_addr=0, x_ins=0, ctrl=0, busy=0. s_ready=1 once rst deasserts. Reset mid-FEED/DRAIN discards buffered vectors and the sweep in progress.
- FIFO: push on s_valid && s_ready; pop only by FSM. s_ready combinational from registered count. When full, s_ready=0; a pop in that cycle makes s_ready=1 the next cycle. Pointers wrap modulo FIFO_DEPTH. Data order preserved.
- State IDLE: ce=0, busy=0, x_ins=0, mem_addr=0.
  - If FIFO non-empty at edge: pop head into x_ins, latch ctrl_in into ctrl, mem_addr=0, ce=1, go FEED.
  - Vector accepted at edge t into an empty FIFO in IDLE appears on x_ins with ce=1 after edge t+1.
- State FEED: ce=1 every cycle, busy=1, x_ins held.
  - mem_addr increments by 1 per cycle while mem_addr < ADDR_COUNT-1.
  - At mem_addr = ADDR_COUNT-1:
    - If FIFO non-empty: pop next vector, mem_addr=0, stay FEED. No bubble; ctrl is not re-latched.
    - Else: x_ins=0, mem_addr=0, go DRAIN.
  - ADDR_COUNT=1: every FEED cycle is a last-address cycle.
- State DRAIN: ce=1, x_ins=0, mem_addr=0, busy=1 for exactly CELLS_PER_ARRAY_COUNT cycles (down-counter), then ce=0 and go IDLE.
  - Vectors arriving during DRAIN are buffered and not consumed until the return to IDLE. They are consumed on the following edge, giving one IDLE cycle with ce=0.
- Per vector: exactly ADDR_COUNT ce cycles. Per burst: one trailing drain of CELLS_PER_ARRAY_COUNT ce cycles.
- No arithmetic on data; lanes are passed bit-exact (signed, unmodified).

Test Plan:
- Reset state: assert rst mid-FEED with 2 vectors buffered -> outputs 0 and busy=0 immediately. After release: s_ready=1, no ce until a new push.
- Single vector, defaults: push 0x030201 at edge t -> after edge t+1, x_ins=0x030201, ce=1, mem_addr 0..15 over 16 cycles. Then 3 cycles ce=1 with x_ins=0, then ce=0 and busy=0.
- Back-to-back: push 0x0A0B0C then 0x7F80FF -> mem_addr 15 for vector A followed directly by mem_addr 0 for vector B with no ce gap. Total 32 feed cycles and 3 drain cycles.
- Backpressure: hold s_valid=1 with 6 distinct vectors while FSM is in FEED -> s_ready drops after 4 buffered (FIFO_DEPTH=4). All 6 vectors emerge in order, none lost or duplicated.
- Drain arrival: push a vector during the 2nd DRAIN cycle -> drain completes 3 cycles, one ce=0 IDLE cycle, then FEED with the new vector at mem_addr 0.
- Ctrl latching: ctrl_in=0x1 at FEED entry and changed to 0x2 mid-burst -> ctrl stays 0x1 until the next IDLE->FEED transition, then 0x2.
